// File: rtl/stream_demux_n_pkg.sv
// stream_demux_pkg: shared types and constants for the stream_demux_n block.
//   demux_mode_e : routing mode (addressed by in_sel, or round-robin).
//   DROP_CNT_W   : width of the saturating illegal-select drop counter.
package stream_demux_pkg;

  typedef enum logic {
    MODE_ADDR = 1'b0,
    MODE_RR   = 1'b1
  } demux_mode_e;

  localparam int DROP_CNT_W = 8;

endpackage

// File: rtl/stream_demux_n_if.sv
// stream_demux_n_if: producer-side and consumer-side handshake bundle of the
// 1-to-N stream demultiplexer.
//   mode, in_valid, in_data, in_sel : producer -> demux
//   in_ready                        : demux -> producer
//   out_valid, out_data             : demux -> consumers (channel k at [k*DATA_W +: DATA_W])
//   out_ready                       : consumers -> demux
// Modports: master = the environment (producer + consumers), slave = the demux.
interface stream_demux_n_if #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 4,
  parameter int SEL_W  = $clog2(N_CH)
);

  logic                   mode;
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_W-1:0]      in_data;
  logic [SEL_W-1:0]       in_sel;
  logic [N_CH-1:0]        out_valid;
  logic [N_CH-1:0]        out_ready;
  logic [N_CH*DATA_W-1:0] out_data;

  modport master (
    output mode, in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  mode, in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/stream_demux_n_slot.sv
// demux_slot: single-entry output buffer for one demux channel.
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : write data_i into the slot this cycle
//   ready_i    : downstream consumer ready
//   data_i     : incoming beat
//   valid_o    : slot holds a beat (registered)
//   data_o     : held beat, keeps its last value while empty (registered)
module demux_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              ready_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  // A load in the same cycle as a drain wins, so the slot stays full with the new beat.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && ready_i) valid_d = 1'b0;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/stream_demux_n.sv
// stream_demux_n: registered 1-to-N stream demultiplexer with valid/ready on
// every port, addressed or round-robin routing and one buffer slot per channel.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : stream_demux_n_if.slave (mode, input stream, N output streams)
//   rr_ptr     : current round-robin target channel
//   drop_cnt   : saturating count of beats discarded for an illegal in_sel
module stream_demux_n
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_CH   = 4,
  parameter int SEL_W  = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  stream_demux_n_if.slave       bus,
  output logic [SEL_W-1:0]      rr_ptr,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam logic [SEL_W:0]   N_CH_EXT = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_CH-1);

  demux_mode_e            mode_s;
  logic [SEL_W-1:0]       tgt;
  logic                   sel_illegal;
  logic                   tgt_blocked;
  logic                   accept;
  logic [N_CH-1:0]        load;
  logic [N_CH-1:0]        slot_vld;
  logic                   slot_vld_a [N_CH];
  logic [DATA_W-1:0]      slot_data  [N_CH];
  logic [N_CH*DATA_W-1:0] out_data_w;
  logic [SEL_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  assign mode_s = demux_mode_e'(bus.mode);
  assign tgt    = (mode_s == MODE_RR) ? rr_ptr_q : bus.in_sel;

  // Only reachable when N_CH is not a power of two; the pointer never leaves 0..N_CH-1.
  assign sel_illegal = (mode_s == MODE_ADDR) && ({1'b0, tgt} >= N_CH_EXT);

  // Target is blocked only when its slot is full and not draining this cycle,
  // so in_ready never depends on in_valid or in_data.
  always_comb begin
    tgt_blocked = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (tgt == SEL_W'(k)) tgt_blocked = slot_vld[k] & ~bus.out_ready[k];
    end
  end

  assign bus.in_ready = sel_illegal | ~tgt_blocked;
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    load = '0;
    for (int k = 0; k < N_CH; k++) begin
      load[k] = accept & ~sel_illegal & (tgt == SEL_W'(k));
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_slot
    demux_slot #(.DATA_W(DATA_W)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load[g]),
      .ready_i (bus.out_ready[g]),
      .data_i  (bus.in_data),
      .valid_o (slot_vld_a[g]),
      .data_o  (slot_data[g])
    );
  end

  always_comb begin
    slot_vld   = '0;
    out_data_w = '0;
    for (int k = 0; k < N_CH; k++) begin
      slot_vld[k]                      = slot_vld_a[k];
      out_data_w[k*DATA_W +: DATA_W] = slot_data[k];
    end
  end

  assign bus.out_valid = slot_vld;
  assign bus.out_data  = out_data_w;

  // Pointer moves only on an accepted round-robin beat, so it holds while
  // stalled and while in addressed mode.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    drop_cnt_d = drop_cnt_q;
    if (accept && sel_illegal) begin
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
    end else if (accept && (mode_s == MODE_RR)) begin
      rr_ptr_d = (rr_ptr_q == LAST_CH) ? '0 : rr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign rr_ptr   = rr_ptr_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_stream_demux_n.sv
// Testbench for stream_demux_n: a 4-channel and a 3-channel instance, directed
// stimulus, a slot-level reference model compared every falling edge, and
// hand-computed literal expectations at key points of each scenario.
module tb_stream_demux_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] rr4, rr3;
  logic [7:0] dc4, dc3;

  stream_demux_n_if #(.DATA_W(8), .N_CH(4)) b4 ();
  stream_demux_n_if #(.DATA_W(8), .N_CH(3)) b3 ();

  stream_demux_n #(.DATA_W(8), .N_CH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .bus(b4), .rr_ptr(rr4), .drop_cnt(dc4)
  );
  stream_demux_n #(.DATA_W(8), .N_CH(3)) u3 (
    .clk(clk), .rst_n(rst_n), .bus(b3), .rr_ptr(rr3), .drop_cnt(dc3)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: per-channel occupancy/data, pointer and drop count.
  logic       mv  [2][16];
  logic [7:0] md  [2][16];
  int         mptr[2];
  int         mdrop[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 16; c++) begin
        mv[k][c] = 1'b0;
        md[k][c] = 8'h00;
      end
      mptr[k]  = 0;
      mdrop[k] = 0;
    end
  endtask

  task automatic model_cmp_step(input int k, input int n, input logic mode, input logic iv,
                                input logic [3:0] sel, input logic [7:0] din,
                                input logic [15:0] ordy, input logic [15:0] ov,
                                input logic [127:0] od, input logic ir,
                                input logic [1:0] rr, input logic [7:0] dc, input logic do_step);
    int   t;
    logic illegal;
    logic exp_rdy;
    t       = mode ? mptr[k] : int'(sel);
    illegal = (t >= n);
    exp_rdy = illegal ? 1'b1 : (!mv[k][t] || ordy[t]);
    chk($sformatf("n%0d in_ready", n), ir, exp_rdy);
    for (int c = 0; c < n; c++) begin
      chk($sformatf("n%0d ch%0d out_valid", n, c), ov[c], mv[k][c]);
      chk($sformatf("n%0d ch%0d out_data", n, c), od[c*8 +: 8], md[k][c]);
    end
    chk($sformatf("n%0d rr_ptr", n), rr, mptr[k]);
    chk($sformatf("n%0d drop_cnt", n), dc, mdrop[k]);
    if (do_step) begin
      for (int c = 0; c < n; c++) if (mv[k][c] && ordy[c]) mv[k][c] = 1'b0;
      if (iv && exp_rdy) begin
        if (illegal) begin
          mdrop[k] = (mdrop[k] == 255) ? 255 : mdrop[k] + 1;
        end else begin
          mv[k][t] = 1'b1;
          md[k][t] = din;
          if (mode) mptr[k] = (mptr[k] + 1) % n;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) model_reset();
    model_cmp_step(0, 4, b4.mode, b4.in_valid, {2'b0, b4.in_sel}, b4.in_data,
                   {12'b0, b4.out_ready}, {12'b0, b4.out_valid}, {96'b0, b4.out_data},
                   b4.in_ready, rr4, dc4, rst_n);
    model_cmp_step(1, 3, b3.mode, b3.in_valid, {2'b0, b3.in_sel}, b3.in_data,
                   {13'b0, b3.out_ready}, {13'b0, b3.out_valid}, {104'b0, b3.out_data},
                   b3.in_ready, rr3, dc3, rst_n);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ch4(input int c);
    return b4.out_data[c*8 +: 8];
  endfunction

  int exp_ch [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    rst_n        = 1'b0;
    b4.mode      = 1'b0; b4.in_valid = 1'b0; b4.in_sel = '0; b4.in_data = '0; b4.out_ready = 4'hF;
    b3.mode      = 1'b0; b3.in_valid = 1'b0; b3.in_sel = '0; b3.in_data = '0; b3.out_ready = 3'h7;
    tick(); tick();

    // Reset state
    chk("rst out_valid", b4.out_valid, 4'h0);
    chk("rst out_data", b4.out_data, 32'h0);
    chk("rst rr_ptr", rr4, 2'd0);
    chk("rst drop_cnt", dc3, 8'd0);
    chk("rst in_ready mode0", b4.in_ready, 1'b1);
    b4.mode = 1'b1; b3.mode = 1'b1;
    #1;
    chk("rst in_ready mode1", b4.in_ready, 1'b1);
    chk("rst in_ready mode1 n3", b3.in_ready, 1'b1);
    b4.mode = 1'b0; b3.mode = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // Addressed routing
    for (int i = 0; i < 4; i++) begin
      b4.in_valid = 1'b1; b4.in_sel = 2'(i); b4.in_data = 8'hA0 + 8'(i);
      tick();
      chk("addr out_valid", b4.out_valid, 4'b0001 << i);
      chk("addr out_data", ch4(i), 8'hA0 + 8'(i));
      chk("addr rr_ptr", rr4, 2'd0);
    end
    b4.in_valid = 1'b0;
    tick();
    chk("addr drained", b4.out_valid, 4'h0);

    // Round-robin, back-to-back
    b4.mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b4.in_valid = 1'b1; b4.in_data = 8'h10 + 8'(i);
      #1;
      chk("rr in_ready", b4.in_ready, 1'b1);
      @(posedge clk); #1;
      chk("rr out_valid", b4.out_valid, 4'b0001 << exp_ch[i]);
      chk("rr out_data", ch4(exp_ch[i]), 8'h10 + 8'(i));
    end
    b4.in_valid = 1'b0;
    chk("rr final ptr", rr4, 2'd2);
    tick();

    // Backpressure on channel 2
    b4.mode = 1'b0; b4.out_ready = 4'b1011;
    b4.in_valid = 1'b1; b4.in_sel = 2'd2; b4.in_data = 8'hB1;
    tick();
    chk("bp first held", ch4(2), 8'hB1);
    b4.in_data = 8'hB2;
    #1;
    chk("bp in_ready low", b4.in_ready, 1'b0);
    @(posedge clk); #1;
    chk("bp still first", ch4(2), 8'hB1);
    chk("bp still valid", b4.out_valid[2], 1'b1);
    b4.out_ready = 4'hF;
    #1;
    chk("bp passthru ready", b4.in_ready, 1'b1);
    @(posedge clk); #1;
    chk("bp reload valid", b4.out_valid[2], 1'b1);
    chk("bp reload data", ch4(2), 8'hB2);
    b4.in_valid = 1'b0;
    tick();
    chk("bp drained", b4.out_valid, 4'h0);

    // Round-robin stall on channel 1 (pointer currently 2)
    b4.mode = 1'b1; b4.in_valid = 1'b1;
    b4.in_data = 8'h22; tick();
    b4.in_data = 8'h23; tick();
    b4.in_data = 8'h20; tick();
    b4.out_ready = 4'b1101;
    b4.in_data = 8'h21; tick();
    b4.in_data = 8'h32; tick();
    b4.in_data = 8'h33; tick();
    b4.in_data = 8'h30; tick();
    chk("stall ptr at 1", rr4, 2'd1);
    chk("stall slot1 data", ch4(1), 8'h21);
    b4.in_data = 8'hC5;
    #1;
    chk("stall in_ready", b4.in_ready, 1'b0);
    @(posedge clk); #1;
    chk("stall ptr holds", rr4, 2'd1);
    chk("stall no skip", b4.out_valid, 4'b0010);
    b4.out_ready = 4'hF;
    #1;
    chk("stall release ready", b4.in_ready, 1'b1);
    @(posedge clk); #1;
    chk("stall land valid", b4.out_valid, 4'b0010);
    chk("stall land data", ch4(1), 8'hC5);
    chk("stall ptr moves", rr4, 2'd2);
    b4.in_valid = 1'b0;
    tick();

    // Illegal select on the 3-channel instance
    b3.mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b3.in_valid = 1'b1; b3.in_sel = 2'd3; b3.in_data = 8'h55;
      #1;
      chk("ill in_ready", b3.in_ready, 1'b1);
      @(posedge clk); #1;
      chk("ill no valid", b3.out_valid, 3'b000);
    end
    b3.in_valid = 1'b0;
    chk("ill drop_cnt", dc3, 8'd3);
    chk("ill rr_ptr", rr3, 2'd0);
    tick();

    // Asynchronous reset mid-stream
    b4.mode = 1'b0; b4.out_ready = 4'b0110;
    b4.in_valid = 1'b1; b4.in_sel = 2'd0; b4.in_data = 8'hD0; tick();
    b4.in_sel = 2'd3; b4.in_data = 8'hD3; tick();
    b4.in_valid = 1'b0;
    chk("arst pre valid", b4.out_valid, 4'b1001);
    chk("arst pre ptr", rr4, 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst out_valid", b4.out_valid, 4'h0);
    chk("arst out_data", b4.out_data, 32'h0);
    chk("arst rr_ptr", rr4, 2'd0);
    chk("arst drop_cnt", dc3, 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; b4.out_ready = 4'hF;

    // Resume after reset
    b4.mode = 1'b1; b4.in_valid = 1'b1; b4.in_data = 8'hE0;
    tick();
    chk("resume valid", b4.out_valid, 4'b0001);
    chk("resume data", ch4(0), 8'hE0);
    chk("resume ptr", rr4, 2'd1);
    b4.in_valid = 1'b0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
